// File: rtl/decoder_2_if.sv
// Handshake bundle for decoder_2: word input channel and decoded output channel.
//   valid_in/ready_in/data_in     : 24-bit word of three SECDED codewords (master -> decoder)
//   valid_out/ready_out           : decoded result handshake (decoder -> master)
//   data_out/status               : 12-bit payload and 2-bit worst-case status
interface decoder_2_if;
    localparam int unsigned WORD_W = 24;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned STAT_W = 2;

    logic              valid_in;
    logic              ready_in;
    logic [WORD_W-1:0] data_in;
    logic              valid_out;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic [STAT_W-1:0] status;

    // Decoder side
    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, status
    );

    // Producer/consumer side
    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, status
    );
endinterface

// File: rtl/decoder_2.sv
// decoder_2: decodes a 24-bit word of three extended Hamming(8,4) codewords, one
// sub-block per clock, correcting single-bit and flagging double-bit errors.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : decoder_2_if.slave (valid_in/ready_in/data_in, valid_out/ready_out/data_out/status)
//   clr_cnt   : synchronous clear of both error counters (wins over increments)
//   corr_cnt  : saturating count of corrected sub-blocks
//   fail_cnt  : saturating count of uncorrectable sub-blocks
module decoder_2 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    decoder_2_if.slave       bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int unsigned WORD_W = 24;
    localparam int unsigned DATA_W = 12;

    typedef enum logic [2:0] {IDLE, DEC0, DEC1, DEC2, DONE} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [1:0]          status_q, status_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    corr_q,  corr_d;
    logic [CNT_W-1:0]    fail_q,  fail_d;

    logic [7:0] sub_c;
    logic [7:0] fixed;
    logic [2:0] syn;
    logic       par;
    logic [3:0] sub_nib;
    logic [1:0] sub_st;
    logic       corr_inc;
    logic       fail_inc;

    // Select the sub-block belonging to the current decode state
    always_comb begin
        sub_c = 8'h00;
        case (state_q)
            DEC0:    sub_c = word_q[7:0];
            DEC1:    sub_c = word_q[15:8];
            DEC2:    sub_c = word_q[23:16];
            default: sub_c = 8'h00;
        endcase
    end

    // SECDED decode of one codeword: syndrome points at the bad bit (1-based)
    always_comb begin
        syn    = {sub_c[3] ^ sub_c[4] ^ sub_c[5] ^ sub_c[6],
                  sub_c[1] ^ sub_c[2] ^ sub_c[5] ^ sub_c[6],
                  sub_c[0] ^ sub_c[2] ^ sub_c[4] ^ sub_c[6]};
        par    = ^sub_c;
        fixed  = sub_c;
        sub_st = 2'b00;
        if (par) begin
            sub_st = 2'b01;
            if (syn != 3'd0) begin
                fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
            end else begin
                fixed[7] = ~fixed[7];
            end
        end else if (syn != 3'd0) begin
            sub_st = 2'b10;
        end
        sub_nib = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        data_d   = data_q;
        status_d = status_q;
        corr_inc = 1'b0;
        fail_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in && ready_q) begin
                    word_d   = bus.data_in;
                    status_d = 2'b00;
                    state_d  = DEC0;
                end
            end
            DEC0, DEC1, DEC2: begin
                case (state_q)
                    DEC0:    data_d[3:0]  = sub_nib;
                    DEC1:    data_d[7:4]  = sub_nib;
                    default: data_d[11:8] = sub_nib;
                endcase
                // Encoding is ordered so numeric max is severity max
                status_d = (sub_st > status_q) ? sub_st : status_q;
                corr_inc = (sub_st == 2'b01);
                fail_inc = (sub_st == 2'b10);
                state_d  = (state_q == DEC0) ? DEC1 :
                           (state_q == DEC1) ? DEC2 : DONE;
            end
            DONE: begin
                if (bus.ready_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // Saturating counters; clear has priority
    always_comb begin
        corr_d = corr_q;
        fail_d = fail_q;
        if (clr_cnt) begin
            corr_d = '0;
            fail_d = '0;
        end else begin
            if (corr_inc && (corr_q != {CNT_W{1'b1}})) begin
                corr_d = corr_q + CNT_W'(1);
            end
            if (fail_inc && (fail_q != {CNT_W{1'b1}})) begin
                fail_d = fail_q + CNT_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            data_q   <= '0;
            status_q <= 2'b00;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            corr_q   <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            data_q   <= data_d;
            status_q <= status_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            corr_q   <= corr_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.ready_in  = ready_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.status    = status_q;
    assign corr_cnt      = corr_q;
    assign fail_cnt      = fail_q;
endmodule
